// File: rtl/sized_data_memory.sv
// Byte-addressable data memory with byte/half/word/dword access, sign/zero-extended registered loads and error flagging.
// Optional macro DMEM_CLEAR_EN builds a post-reset CLEAR state that zeroes every word before ready rises.
module sized_data_memory #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              err,
  output logic              ready
);

  localparam int LANES = DATA_W / 8;
  localparam int LSB_W = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_RESET, S_CLEAR, S_RUN} state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] word_full;
  logic [IDX_W-1:0]  idx;
  logic [LSB_W-1:0]  lane;
  logic              out_of_range;
  logic              misaligned;
  logic              bad_size;
  logic              access_err;
  logic              accept;
  logic              do_store;
  logic [LANES-1:0]  size_mask;
  logic [LANES-1:0]  byte_en;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] load_shift;
  logic [DATA_W-1:0] keep_mask;
  logic              load_sign;
  logic [DATA_W-1:0] load_ext;

`ifdef DMEM_CLEAR_EN
  logic [IDX_W-1:0]  clr_cnt;
`endif

  // Address decode and access checks
  always_comb begin
    offset       = address - BASE_ADDR;
    word_full    = offset >> LSB_W;
    idx          = word_full[IDX_W-1:0];
    lane         = offset[LSB_W-1:0];
    out_of_range = (address < BASE_ADDR) || (word_full >= ADDR_W'(DEPTH_WORDS));
    case (mem_size)
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = (offset[1:0] != 2'b00);
      2'b11:   misaligned = (offset[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
    bad_size   = (mem_size == 2'b11) && (DATA_W == 32);
    access_err = out_of_range || misaligned || bad_size;
    accept     = (state == S_RUN);
    do_store   = accept && mem_write && !access_err;
  end

  // Lane enables and store data aligned to the addressed byte lane
  always_comb begin
    case (mem_size)
      2'b00:   size_mask = LANES'(8'h01);
      2'b01:   size_mask = LANES'(8'h03);
      2'b10:   size_mask = LANES'(8'h0F);
      default: size_mask = '1;
    endcase
    byte_en    = size_mask << lane;
    store_data = write_data << {lane, 3'b000};
  end

  // Load path: shift the addressed lanes to bit 0, then extend
  always_comb begin
    load_word  = mem[idx];
    load_shift = load_word >> {lane, 3'b000};
    case (mem_size)
      2'b00: begin
        keep_mask = DATA_W'(8'hFF);
        load_sign = load_shift[7];
      end
      2'b01: begin
        keep_mask = DATA_W'(16'hFFFF);
        load_sign = load_shift[15];
      end
      2'b10: begin
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        load_sign = load_shift[31];
      end
      default: begin
        keep_mask = '1;
        load_sign = load_shift[DATA_W-1];
      end
    endcase
    load_ext = (load_shift & keep_mask) | ({DATA_W{load_sign & ~mem_unsigned}} & ~keep_mask);
  end

  // Storage array: no reset so it maps onto RAM; clear and store never overlap
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
    if (state == S_CLEAR) begin
      mem[clr_cnt] <= '0;
    end
`endif
    if (do_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en[i]) begin
          mem[idx][i*8 +: 8] <= store_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RESET;
      ready      <= 1'b0;
      read_data  <= '0;
      read_valid <= 1'b0;
      err        <= 1'b0;
`ifdef DMEM_CLEAR_EN
      clr_cnt    <= '0;
`endif
    end else begin
      read_valid <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_RESET: begin
`ifdef DMEM_CLEAR_EN
          state <= S_CLEAR;
`else
          state <= S_RUN;
          ready <= 1'b1;
`endif
        end
`ifdef DMEM_CLEAR_EN
        S_CLEAR: begin
          clr_cnt <= clr_cnt + IDX_W'(1);
          if (clr_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
`endif
        S_RUN: begin
          if ((mem_read || mem_write) && access_err) begin
            err       <= 1'b1;
            read_data <= '0;
          end else if (mem_read) begin
            read_data  <= load_ext;
            read_valid <= 1'b1;
          end
        end
        default: begin
          state <= S_RESET;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Self-checking bench for sized_data_memory: directed vector table, reset/clear sequences,
// and randomized traffic checked against a byte-array reference model.
module tb_sized_data_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        mem_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        err;
  logic        ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [1024];
  logic [31:0] ref_last = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_v;
    logic        exp_e;
  } vec_t;

  vec_t vecs [24];

  sized_data_memory dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .err          (err),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read     = rd;
    mem_write    = wr;
    mem_size     = sz;
    mem_unsigned = uns;
    address      = a;
    write_data   = wd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: memory as a flat byte array, values composed with plain arithmetic
  task automatic model(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] e_data, output logic e_v, output logic e_e);
    int     nb;
    longint val;
    bit     bad;
    nb  = 1 << sz;
    bad = (sz == 2'd3) || (a >= 32'd1024) || ((a % nb) != 0);
    e_v = 1'b0;
    e_e = 1'b0;
    if (rd || wr) begin
      if (bad) begin
        e_e      = 1'b1;
        ref_last = '0;
      end else begin
        if (rd) begin
          val = 0;
          for (int i = 0; i < nb; i++) val += longint'(ref_mem[a + i]) << (8 * i);
          if (!uns && val >= (longint'(1) << (8 * nb - 1))) val -= longint'(1) << (8 * nb);
          ref_last = 32'(val);
          e_v      = 1'b1;
        end
        if (wr) begin
          for (int i = 0; i < nb; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
        end
      end
    end
    e_data = ref_last;
  endtask

  task automatic setv(input int i, input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ed,
                      input logic ev, input logic ee);
    vecs[i] = '{rd, wr, sz, uns, a, wd, ed, ev, ee};
  endtask

  task automatic wait_ready(input int expect_edges, input string name);
    int  edges;
    bit  quiet;
    edges = 0;
    quiet = 1'b1;
    while (!ready && edges < 600) begin
      step();
      edges++;
      if (err || read_valid) quiet = 1'b0;
    end
    chk({name, "_ready"}, 32'(ready), 32'd1);
    chk({name, "_edges"}, 32'(edges), 32'(expect_edges));
    chk({name, "_quiet"}, 32'(quiet), 32'd1);
  endtask

  initial begin
    logic [31:0] e_data;
    logic        e_v;
    logic        e_e;
    int          exp_edges;
    logic        r_rd, r_wr, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_addr, r_wd;
    int          r;

`ifdef DMEM_CLEAR_EN
    exp_edges = 257;
`else
    exp_edges = 1;
`endif
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    // Reset state, with a request held that must be ignored while not ready
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    step();
    step();
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_read_valid", 32'(read_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;
    wait_ready(exp_edges, "startup");
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

`ifdef DMEM_CLEAR_EN
    // Reset pulse in the middle of clearing restarts the clear from index 0
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 101; k++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_ready", 32'(ready), 32'd0);
    chk("midclr_err", 32'(err), 32'd0);
    chk("midclr_read_data", read_data, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h4, 32'hFFFF_FFFF);
    wait_ready(257, "restart");
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    step();
    chk("cleared_load", read_data, 32'h0);
    chk("cleared_load_v", 32'(read_valid), 32'd1);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
`endif

    // Directed vectors
    setv(0,  0, 1, 2, 0, 32'h004, 32'hDEADBEEF, 32'h00000000, 0, 0);
    setv(1,  1, 0, 2, 0, 32'h004, 32'h0,        32'hDEADBEEF, 1, 0);
    setv(2,  0, 1, 2, 0, 32'h008, 32'hBEEFDEAD, 32'hDEADBEEF, 0, 0);
    setv(3,  1, 0, 2, 0, 32'h008, 32'h0,        32'hBEEFDEAD, 1, 0);
    setv(4,  0, 1, 0, 0, 32'h005, 32'h000000AA, 32'hBEEFDEAD, 0, 0);
    setv(5,  1, 0, 0, 0, 32'h005, 32'h0,        32'hFFFFFFAA, 1, 0);
    setv(6,  1, 0, 0, 1, 32'h005, 32'h0,        32'h000000AA, 1, 0);
    setv(7,  1, 0, 2, 0, 32'h004, 32'h0,        32'hDEADAAEF, 1, 0);
    setv(8,  1, 0, 1, 0, 32'h006, 32'h0,        32'hFFFFDEAD, 1, 0);
    setv(9,  1, 0, 1, 1, 32'h006, 32'h0,        32'h0000DEAD, 1, 0);
    setv(10, 0, 1, 2, 0, 32'h006, 32'h11111111, 32'h00000000, 0, 1);
    setv(11, 1, 0, 2, 0, 32'h004, 32'h0,        32'hDEADAAEF, 1, 0);
    setv(12, 1, 0, 2, 0, 32'h400, 32'h0,        32'h00000000, 0, 1);
    setv(13, 0, 1, 2, 0, 32'h008, 32'h12345678, 32'h00000000, 0, 0);
    setv(14, 1, 1, 2, 0, 32'h008, 32'hCAFEF00D, 32'h12345678, 1, 0);
    setv(15, 1, 0, 2, 0, 32'h008, 32'h0,        32'hCAFEF00D, 1, 0);
    setv(16, 0, 1, 2, 0, 32'h3FC, 32'h0BADCAFE, 32'hCAFEF00D, 0, 0);
    setv(17, 1, 0, 2, 0, 32'h3FC, 32'h0,        32'h0BADCAFE, 1, 0);
    setv(18, 1, 0, 1, 0, 32'h007, 32'h0,        32'h00000000, 0, 1);
    setv(19, 1, 0, 3, 0, 32'h000, 32'h0,        32'h00000000, 0, 1);
    setv(20, 0, 1, 1, 0, 32'h3FE, 32'h00008001, 32'h00000000, 0, 0);
    setv(21, 1, 0, 2, 0, 32'h3FC, 32'h0,        32'h8001CAFE, 1, 0);
    setv(22, 1, 0, 0, 0, 32'h3FF, 32'h0,        32'hFFFFFF80, 1, 0);
    setv(23, 0, 1, 2, 0, 32'h3FD, 32'h55555555, 32'h00000000, 0, 1);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      step();
      model(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, e_data, e_v, e_e);
      $display("vec %0d rd=%0b wr=%0b size=%0d uns=%0b addr=%h wdata=%h -> data=%h v=%0b e=%0b",
               i, vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
               read_data, read_valid, err);
      chk($sformatf("vec%0d_data", i), read_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_valid", i), 32'(read_valid), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_e));
    end

    // Fill every word so random loads only see defined contents
    for (int w = 0; w < 256; w++) begin
      r_wd = $urandom;
      drive(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), r_wd);
      step();
      model(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), r_wd, e_data, e_v, e_e);
    end
    chk("fill_err", 32'(err), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      r      = $urandom_range(0, 99);
      r_rd   = 1'($urandom_range(0, 1));
      r_wr   = 1'($urandom_range(0, 1));
      r_sz   = 2'($urandom_range(0, 3));
      r_uns  = 1'($urandom_range(0, 1));
      r_wd   = $urandom;
      if (r < 10) begin
        r_addr = $urandom_range(1024, 4095);
      end else begin
        r_addr = $urandom_range(0, 1023);
        if (r < 75) r_addr = r_addr & ~(32'(1 << r_sz) - 32'd1);
      end
      drive(r_rd, r_wr, r_sz, r_uns, r_addr, r_wd);
      step();
      model(r_rd, r_wr, r_sz, r_uns, r_addr, r_wd, e_data, e_v, e_e);
      $display("rnd %0d rd=%0b wr=%0b size=%0d uns=%0b addr=%h -> data=%h v=%0b e=%0b",
               n, r_rd, r_wr, r_sz, r_uns, r_addr, read_data, read_valid, err);
      chk($sformatf("rnd%0d_data", n), read_data, e_data);
      chk($sformatf("rnd%0d_valid", n), 32'(read_valid), 32'(e_v));
      chk($sformatf("rnd%0d_err", n), 32'(err), 32'(e_e));
    end

    // Reset during an access: outputs drop at once, a pending store is lost
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    step();
    model(1'b1, 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, e_data, e_v, e_e);
    chk("pre_rst_data", read_data, e_data);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hA5A5_5A5A);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", read_data, 32'h0);
    chk("async_rst_valid", 32'(read_valid), 32'd0);
    chk("async_rst_ready", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    wait_ready(exp_edges, "rerun");
`ifdef DMEM_CLEAR_EN
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
`endif
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    step();
    model(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_data, e_v, e_e);
    chk("lost_store_data", read_data, e_data);
    chk("lost_store_valid", 32'(read_valid), 32'd1);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    step();
    chk("valid_pulse_end", 32'(read_valid), 32'd0);
    chk("data_hold", read_data, e_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
